// File: rtl/step_dir_decoder_if.sv
// Step/dir decoder bundle: raw step/dir inputs, position controls and
// decoded motion status outputs.
interface step_dir_decoder_if;
  logic        step_in;
  logic        dir_in;
  logic        clear_pos;
  logic        load_pos;
  logic [31:0] load_value;
  logic        err_clear;
  logic [31:0] position;
  logic        step_strobe;
  logic        direction;
  logic [31:0] step_period;
  logic        moving;
  logic        glitch_err;
  logic        dir_err;

  modport slave (
    input  step_in, dir_in, clear_pos, load_pos,
    input  load_value, err_clear,
    output position, step_strobe, direction,
    output step_period, moving, glitch_err, dir_err
  );

  modport master (
    output step_in, dir_in, clear_pos, load_pos,
    output load_value, err_clear,
    input  position, step_strobe, direction,
    input  step_period, moving, glitch_err, dir_err
  );
endinterface

// File: rtl/step_dir_decoder.sv
// Step/dir decoder: synchronizes async step/dir, qualifies pulse width and
// dir setup, and tracks position, step period and motion state.
module step_dir_decoder #(
  parameter int MIN_PULSE    = 2,
  parameter int DIR_SETUP    = 2,
  parameter int IDLE_TIMEOUT = 1000000
) (
  input logic                clk,
  input logic                rst_n,
  step_dir_decoder_if.slave  bus
);

  localparam logic [15:0] MIN_W   = 16'(MIN_PULSE);
  localparam logic [15:0] SETUP_W = 16'(DIR_SETUP);
  localparam logic [31:0] IDLE_W  = 32'(IDLE_TIMEOUT);

  typedef enum logic {LOW, HIGH} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        step_s1;
  logic        step_s2;
  logic        dir_s1;
  logic        dir_s2;
  logic        dir_prev;
  logic [1:0]  valid_sr;
  logic        armed;
  logic [15:0] high_cnt;
  logic [15:0] dir_cnt;
  logic        pend_dir;
  logic [31:0] period_cnt;
  logic [31:0] acc_pos;
  logic        strobe;
  logic        last_dir;
  logic [31:0] period;
  logic        move;
  logic        glitch_flag;
  logic        dir_flag;

  logic        dir_chg;
  logic [15:0] dir_eff;
  logic        rise;
  logic        fall;
  logic        accept;
  logic        glitch;
  logic        dir_bad;
  logic [31:0] pos_nxt;

  // Event detection; rise needs a real low seen since reset (armed)
  always_comb begin
    dir_chg = dir_s2 ^ dir_prev;
    dir_eff = dir_chg ? 16'd0 : dir_cnt;
    rise    = (state == LOW) && valid_sr[1] && armed && step_s2;
    fall    = (state == HIGH) && !step_s2;
    accept  = fall && (high_cnt >= MIN_W);
    glitch  = fall && !accept;
    dir_bad = (rise && (dir_eff < SETUP_W))
           || ((state == HIGH) && step_s2 && dir_chg);
    pos_nxt = acc_pos;
    if (bus.clear_pos)
      pos_nxt = 32'd0;
    else if (bus.load_pos)
      pos_nxt = bus.load_value;
    else if (accept)
      pos_nxt = pend_dir ? acc_pos - 32'd1 : acc_pos + 32'd1;
  end

  // Step FSM next-state
  always_comb begin
    state_nxt = state;
    unique case (state)
      LOW:  if (rise) state_nxt = HIGH;
      HIGH: if (!step_s2) state_nxt = LOW;
      default: state_nxt = LOW;
    endcase
  end

  // Step FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= LOW;
    else        state <= state_nxt;
  end

  // Synchronizers, width/setup counters and pending direction
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_s1  <= 1'b0;
      step_s2  <= 1'b0;
      dir_s1   <= 1'b0;
      dir_s2   <= 1'b0;
      dir_prev <= 1'b0;
      valid_sr <= 2'b00;
      armed    <= 1'b0;
      high_cnt <= 16'd0;
      dir_cnt  <= 16'd0;
      pend_dir <= 1'b0;
    end else begin
      step_s1  <= bus.step_in;
      step_s2  <= step_s1;
      dir_s1   <= bus.dir_in;
      dir_s2   <= dir_s1;
      dir_prev <= dir_s2;
      valid_sr <= {valid_sr[0], 1'b1};
      if (valid_sr[1] && !step_s2)
        armed <= 1'b1;
      if (rise) begin
        pend_dir <= dir_s2;
        high_cnt <= 16'd1;
      end else if ((state == HIGH) && step_s2 && (high_cnt != 16'hFFFF)) begin
        high_cnt <= high_cnt + 16'd1;
      end
      if (dir_chg)
        dir_cnt <= 16'd0;
      else if (dir_cnt != 16'hFFFF)
        dir_cnt <= dir_cnt + 16'd1;
    end
  end

  // Position, strobe, period/motion tracking and sticky errors
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_pos     <= 32'd0;
      strobe      <= 1'b0;
      last_dir    <= 1'b0;
      period_cnt  <= 32'd0;
      period      <= 32'd0;
      move        <= 1'b0;
      glitch_flag <= 1'b0;
      dir_flag    <= 1'b0;
    end else begin
      acc_pos <= pos_nxt;
      strobe  <= accept;
      if (accept) begin
        last_dir   <= pend_dir;
        period_cnt <= 32'd1;
        period     <= move ? period_cnt : 32'd0;
        move       <= 1'b1;
      end else begin
        if (period_cnt != 32'hFFFF_FFFF)
          period_cnt <= period_cnt + 32'd1;
        if (period_cnt == IDLE_W) begin
          move   <= 1'b0;
          period <= 32'd0;
        end
      end
      glitch_flag <= glitch || (glitch_flag && !bus.err_clear);
      dir_flag    <= dir_bad || (dir_flag && !bus.err_clear);
    end
  end

  assign bus.position    = acc_pos;
  assign bus.step_strobe = strobe;
  assign bus.direction   = last_dir;
  assign bus.step_period = period;
  assign bus.moving      = move;
  assign bus.glitch_err  = glitch_flag;
  assign bus.dir_err     = dir_flag;

endmodule

// File: doc/step_dir_decoder.md
STEP_DIR_DECODER -- requirements
Module: step_dir_decoder

Interface
REQ-001 Parameter MIN_PULSE, default 2: minimum synchronized step-high width in clk cycles for a step to be accepted.
REQ-002 Parameter DIR_SETUP, default 2: minimum clk cycles dir must be stable before a step rising edge.
REQ-003 Parameter IDLE_TIMEOUT, default 1000000: clk cycles without an accepted step before motion is declared stopped.
REQ-004 The block SHALL use one clock; reset is synchronous and active-low.
REQ-005 clk  input  1  system clock, all logic on rising edge.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 step_in  input  1  asynchronous step pulse; one high pulse = one step.
REQ-008 dir_in  input  1  asynchronous direction; 0 = positive, 1 = negative.
REQ-009 clear_pos  input  1  position := 0.
REQ-010 load_pos  input  1  position := load_value.
REQ-011 load_value  input  32  signed preset value.
REQ-012 err_clear  input  1  clears sticky error flags.
REQ-013 position  output  32  signed accumulated position, two's complement.
REQ-014 step_strobe  output  1  one-cycle pulse per accepted step.
REQ-015 direction  output  1  direction latched for the last accepted step.
REQ-016 step_period  output  32  clk cycles between the last two accepted steps; 0 if unknown.
REQ-017 moving  output  1  high while steps arrive within IDLE_TIMEOUT.
REQ-018 glitch_err  output  1  sticky: step-high pulse shorter than MIN_PULSE seen.
REQ-019 dir_err  output  1  sticky: DIR_SETUP violated or dir changed while step high.

Function
REQ-020 step_in and dir_in SHALL each pass through a 2-flop synchronizer; all logic uses the synchronized versions only.
REQ-021 FSM states: LOW, HIGH; LOW->HIGH on synchronized step rising edge; HIGH->LOW on synchronized falling edge.
REQ-022 On LOW->HIGH, the synchronized dir SHALL be latched as the pending step direction, and the high-width counter is set to 1.
REQ-023 In HIGH, the high-width counter SHALL increment each cycle, 16-bit, saturating at 0xFFFF.
REQ-024 On HIGH->LOW, the step is accepted if high width >= MIN_PULSE; otherwise it is discarded and glitch_err is set.
REQ-025 Accepted step: position +1 if pending direction = 0, -1 if 1; 32-bit wrap (0x7FFFFFFF+1 = 0x80000000, 0x80000000-1 = 0x7FFFFFFF).
REQ-026 Accepted step SHALL update position, step_strobe, and direction on the 3rd rising clk edge after step_in falls (2 sync + 1 register).
REQ-027 A dir-stable counter (16-bit, saturating) resets to 0 on each synchronized dir change; if < DIR_SETUP at a step rising edge, dir_err is set and the step is still processed.
REQ-028 A synchronized dir change while in HIGH SHALL set dir_err; the latched pending direction is used.
REQ-029 Period counter: set to 1 on an accepted step, else increments, saturating at 0xFFFFFFFF.
REQ-030 On an accepted step: step_period := period counter if moving = 1, else 0; moving := 1.
REQ-031 When the period counter reaches IDLE_TIMEOUT with no accepted step, moving := 0 and step_period := 0.
REQ-032 Priority within a cycle: clear_pos > load_pos > step update; a coincident accepted step is dropped from position, but step_strobe, direction, and period are still updated.
REQ-033 err_clear clears both sticky flags; a same-cycle new error SHALL win (flag remains 1).

Reset
REQ-034 rst_n = 0 at a clk edge: state LOW; synchronizers, counters, position, step_strobe, direction, step_period, moving, glitch_err, and dir_err all SHALL be 0.
REQ-035 Reset mid-pulse (state HIGH): the pulse is discarded; a step_in still high after release is not counted until it goes low and then high again.

Verification
REQ-036 After reset, 5 pulses of dir = 0, 4 cycles high and 10 cycles low -> position = 5, 5 strobes, step_period = 14 after the 2nd step, moving = 1.
REQ-037 From position 0x7FFFFFFF, 1 step with dir = 0 -> 0x80000000; then 2 steps with dir = 1 -> 0x7FFFFFFE, direction = 1.
REQ-038 A 1-cycle step pulse with MIN_PULSE = 2 -> position unchanged, no strobe, glitch_err = 1; then err_clear -> glitch_err = 0.
REQ-039 Dir toggled 1 cycle before the step rising edge -> dir_err = 1 and the step is counted with the new dir; dir toggled mid-high -> dir_err = 1 and the step uses the old dir.
REQ-040 Step accepted in the same cycle as load_pos = 100 -> position = 100, step_strobe = 1; with IDLE_TIMEOUT = 50 and no further steps -> moving = 0 and step_period = 0 at 50 cycles.
REQ-041 rst_n low while step_in is high, then released -> all outputs 0 and no step counted until the next full pulse.
